brick_field: RTL and testbench



---
 rtl/brick_pkg.sv | 23 ++
 rtl/brick_field_if.sv | 12 +
 rtl/brick_pixel_map.sv | 28 ++
 rtl/brick_field.sv | 97 +++++++++
 tb/tb_brick_field.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/brick_pkg.sv
// Shared constants, state encoding and bitmap indexing for the brick wall.
package brick_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 10;
  localparam int BRICK_W = 64;
  localparam int BRICK_H = 20;

  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int IDX_W = $clog2(ROWS * COLS);

  localparam logic [7:0] KEY_RESTART = 8'h15;

  typedef enum logic [1:0] {LOAD, PLAY, CLEARED} field_state_t;

  // Bit position of (row, col) in the alive bitmap.
  function automatic logic [IDX_W-1:0] idx(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// Ball <-> field link: break reports flow in, the alive bitmap flows back.
interface brick_field_if;
  import brick_pkg::*;

  logic                   brick_broke;
  logic [9:0]             break_row;
  logic [9:0]             break_col;
  logic [ROWS*COLS-1:0]   bricks;

  modport master (output brick_broke, break_row, break_col, input bricks);
  modport slave  (input brick_broke, break_row, break_col, output bricks);
endinterface

// File: rtl/brick_pixel_map.sv
// Combinational pixel -> brick face lookup; mortar lines sit on zero remainders.
module brick_pixel_map
  import brick_pkg::*;
(
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [ROWS*COLS-1:0] bricks,
  output logic                 pix_is_brick,
  output logic [2:0]           pix_row
);

  localparam logic [9:0] BW = 10'(BRICK_W);
  localparam logic [9:0] BH = 10'(BRICK_H);

  logic [9:0] row, col;
  assign row = DrawY / BH;
  assign col = DrawX / BW;
  assign pix_row = row[2:0];

  // Face pixel only inside the wall, off mortar lines, on a live brick.
  always_comb begin
    pix_is_brick = 1'b0;
    if (row < 10'(ROWS) && col < 10'(COLS) &&
        (DrawX % BW) != 10'd0 && (DrawY % BH) != 10'd0)
      pix_is_brick = bricks[idx(row[ROW_W-1:0], col[COL_W-1:0])];
  end

endmodule

// File: rtl/brick_field.sv
// Brick wall owner: row-by-row load, break accounting, score, level-clear flag.
module brick_field
  import brick_pkg::*;
#(
  parameter int PTS_PER_BRICK = 10
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   key,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  brick_field_if.slave bif,
  output logic [5:0]   bricks_left,
  output logic [15:0]  score,
  output logic         field_ready,
  output logic         cleared,
  output logic         pix_is_brick,
  output logic [2:0]   pix_row
);

  field_state_t         state;
  logic [ROW_W-1:0]     load_row;
  logic [ROWS*COLS-1:0] bricks_q;

  assign bif.bricks = bricks_q;

  // A break only counts when it addresses a real, still-live brick.
  logic [IDX_W-1:0] hit_idx;
  logic             hit;
  assign hit_idx = idx(bif.break_row[ROW_W-1:0], bif.break_col[COL_W-1:0]);
  assign hit = bif.brick_broke && (bif.break_row < 10'(ROWS)) &&
               (bif.break_col < 10'(COLS)) && bricks_q[hit_idx];

  // Score add saturates instead of wrapping.
  logic [16:0] score_sum;
  logic [15:0] score_nxt;
  assign score_sum = {1'b0, score} + 17'(PTS_PER_BRICK);
  assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Field FSM; restart key overrides everything including a same-frame break.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= LOAD;
      load_row    <= '0;
      bricks_q    <= '0;
      bricks_left <= '0;
      score       <= '0;
      field_ready <= 1'b0;
      cleared     <= 1'b0;
    end else if (key == KEY_RESTART) begin
      state       <= LOAD;
      load_row    <= '0;
      bricks_q    <= '0;
      bricks_left <= '0;
      score       <= '0;
      field_ready <= 1'b0;
      cleared     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // load_row runs one past the last row so PLAY starts a frame later
          if (load_row < ROW_W'(ROWS)) begin
            bricks_q[idx(load_row, '0) +: COLS] <= '1;
            bricks_left <= bricks_left + 6'(COLS);
            load_row    <= load_row + 1'b1;
          end else begin
            state       <= PLAY;
            field_ready <= 1'b1;
          end
        end
        PLAY: begin
          if (hit) begin
            bricks_q[hit_idx] <= 1'b0;
            bricks_left       <= bricks_left - 6'd1;
            score             <= score_nxt;
            if (bricks_left == 6'd1) begin
              state       <= CLEARED;
              field_ready <= 1'b0;
              cleared     <= 1'b1;
            end
          end
        end
        CLEARED: ;
        default: state <= LOAD;
      endcase
    end
  end

  brick_pixel_map u_pix (
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .bricks       (bricks_q),
    .pix_is_brick (pix_is_brick),
    .pix_row      (pix_row)
  );

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: load, breaks, restart, clear, pixel lookup.
module tb_brick_field;
  import brick_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  key;
  logic [9:0]  DrawX, DrawY;
  logic [5:0]  bricks_left;
  logic [15:0] score;
  logic        field_ready, cleared, pix_is_brick;
  logic [2:0]  pix_row;

  brick_field_if bif ();

  brick_field dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .key          (key),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .bif          (bif),
    .bricks_left  (bricks_left),
    .score        (score),
    .field_ready  (field_ready),
    .cleared      (cleared),
    .pix_is_brick (pix_is_brick),
    .pix_row      (pix_row)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic brk(input logic b, input int r, input int c);
    bif.brick_broke = b;
    bif.break_row   = 10'(r);
    bif.break_col   = 10'(c);
  endtask

  task automatic field_chk(input string tag, input logic [39:0] eb, input int el,
                           input int es, input logic er, input logic ec);
    check({tag, ".bricks"}, 64'(bif.bricks), 64'(eb));
    check({tag, ".left"},   64'(bricks_left), 64'(el));
    check({tag, ".score"},  64'(score), 64'(es));
    check({tag, ".ready"},  64'(field_ready), 64'(er));
    check({tag, ".clear"},  64'(cleared), 64'(ec));
  endtask

  task automatic pix_chk(input string tag, input int x, input int y,
                         input logic eis, input int erow);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check({tag, ".is"}, 64'(pix_is_brick), 64'(eis));
    if (eis) check({tag, ".row"}, 64'(pix_row), 64'(erow));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] eb;
    int k;
    Reset = 1'b1; key = 8'h00; DrawX = '0; DrawY = '0;
    brk(1'b0, 0, 0);
    tick; tick;
    field_chk("reset", 40'h0, 0, 0, 1'b0, 1'b0);
    Reset = 1'b0;

    // Load with a live-looking break held: LOAD must ignore it
    brk(1'b1, 0, 0);
    eb = '0;
    for (int f = 1; f <= 5; f++) begin
      if (f == 5) brk(1'b0, 0, 0);
      tick;
      if (f <= 4) eb = eb | (40'h3FF << (10 * (f - 1)));
      field_chk($sformatf("load%0d", f), eb, (f <= 4) ? 10 * f : 40, 0, f == 5, 1'b0);
    end
    check("load.full", 64'(bif.bricks), 64'h00FF_FFFF_FFFF);

    // Pixel lookup on a full wall
    pix_chk("pix_face", 70, 25, 1'b1, 1);
    pix_chk("pix_mortar_x", 64, 25, 1'b0, 0);
    pix_chk("pix_mortar_y", 70, 20, 1'b0, 0);
    pix_chk("pix_below", 70, 80, 1'b0, 0);
    pix_chk("pix_row3", 639, 79, 1'b1, 3);

    // Break (2,3) -> bit 23
    brk(1'b1, 2, 3); tick;
    field_chk("brk23", 40'hFF_FF7F_FFFF, 39, 10, 1'b1, 1'b0);
    tick;
    field_chk("brk23_again", 40'hFF_FF7F_FFFF, 39, 10, 1'b1, 1'b0);
    brk(1'b1, 4, 0); tick;
    field_chk("brk_row_oor", 40'hFF_FF7F_FFFF, 39, 10, 1'b1, 1'b0);
    brk(1'b1, 0, 10); tick;
    field_chk("brk_col_oor", 40'hFF_FF7F_FFFF, 39, 10, 1'b1, 1'b0);

    // Break (1,1) -> bit 11, pixel face goes dark
    brk(1'b1, 1, 1); tick;
    field_chk("brk11", 40'hFF_FF7F_F7FF, 38, 20, 1'b1, 1'b0);
    pix_chk("pix_dead", 70, 25, 1'b0, 0);

    // Bring score to 50
    brk(1'b1, 0, 0); tick;
    brk(1'b1, 0, 1); tick;
    brk(1'b1, 0, 2); tick;
    field_chk("score50", 40'hFF_FF7F_F7F8, 35, 50, 1'b1, 1'b0);

    // Restart with a simultaneous live break: restart wins
    key = KEY_RESTART;
    brk(1'b1, 3, 9); tick;
    field_chk("restart", 40'h0, 0, 0, 1'b0, 1'b0);
    brk(1'b0, 0, 0); tick;
    field_chk("restart_held", 40'h0, 0, 0, 1'b0, 1'b0);
    key = 8'h00;
    eb = '0;
    for (int f = 1; f <= 5; f++) begin
      tick;
      if (f <= 4) eb = eb | (40'h3FF << (10 * (f - 1)));
      field_chk($sformatf("reload%0d", f), eb, (f <= 4) ? 10 * f : 40, 0, f == 5, 1'b0);
    end

    // Break every brick; the 40th clears the level on its own edge
    k = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        brk(1'b1, r, c); tick;
        k++;
        eb[r * COLS + c] = 1'b0;
        check($sformatf("all%0d.left", k), 64'(bricks_left), 64'(40 - k));
        check($sformatf("all%0d.score", k), 64'(score), 64'(10 * k));
        check($sformatf("all%0d.clear", k), 64'(cleared), 64'(k == 40));
        check($sformatf("all%0d.bricks", k), 64'(bif.bricks), 64'(eb));
      end
    end
    field_chk("cleared", 40'h0, 0, 400, 1'b0, 1'b1);
    brk(1'b1, 0, 0); tick;
    field_chk("cleared_brk", 40'h0, 0, 400, 1'b0, 1'b1);
    brk(1'b0, 0, 0);

    // Reset mid-PLAY behaves like power-up
    key = KEY_RESTART; tick;
    key = 8'h00;
    for (int f = 1; f <= 5; f++) tick;
    brk(1'b1, 3, 9); tick;
    brk(1'b0, 0, 0);
    field_chk("pre_reset", 40'h7F_FFFF_FFFF, 39, 10, 1'b1, 1'b0);
    Reset = 1'b1; #2;
    field_chk("async_reset", 40'h0, 0, 0, 1'b0, 1'b0);
    tick;
    Reset = 1'b0;
    tick;
    field_chk("post_reset", 40'h3FF, 10, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
